// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   UART_DATA_W : width of one UART byte
//   txq_state_t : hand-off FSM states of uart_tx_queue
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular-buffer FIFO with registered occupancy flags.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push_i, wdata_i : enqueue request/data (ignored while full)
//   pop_i           : dequeue request (ignored while empty)
//   rdata_o         : current head entry (valid when empty_o=0)
//   full_o, empty_o : registered occupancy flags
//   count_o         : registered occupancy
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       count_q, count_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  // Gate on the pre-edge flags: a push while full is lost even if a pop
  // frees a slot in the same cycle.
  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i  & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and pacing stage in front of the UART transmitter.
// Bytes are buffered in a FIFO and issued one at a time as a one-cycle
// tx_valid pulse; the next byte waits for tx_done plus GAP_CYCLES idle clocks.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   wr_data, wr_en        : enqueue byte (dropped while full)
//   full, empty, count    : registered FIFO occupancy
//   tx_data, tx_valid     : to transmitter data_in / input_valid
//   tx_done               : transmitter frame-complete pulse
//   busy                  : hand-off FSM not idle
//   overflow              : sticky dropped-write flag
// Build option: define UART_TXQ_OVERFLOW_EN to build the overflow flag;
// otherwise overflow is tied low.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [UART_DATA_W-1:0] tx_data,
  output logic                   tx_valid,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   overflow
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  txq_state_t             state_q, state_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  uart_sync_fifo #(.DEPTH(DEPTH), .DATA_W(UART_DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop        = 1'b1;
        tx_data_d  = head;
        tx_valid_d = 1'b1;     // registered, so the pulse lands in ISSUE
        state_d    = ISSUE;
      end
      ISSUE: state_d = WAIT;   // tx_done in this cycle is deliberately ignored
      WAIT: if (tx_done) begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

`ifdef UART_TXQ_OVERFLOW_EN
  logic ovf_q, ovf_d;
  assign ovf_d = ovf_q | (wr_en & full);
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: two instances (A: DEPTH=4 GAP=0, B: DEPTH=16
// GAP=3) share write/reset stimulus, each with its own tx_done responder.
module tb_uart_tx_queue;

  localparam int ND[2] = '{4, 16};
  localparam int NG[2] = '{0, 3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [1:0] man_done = 2'b00;
  logic [1:0] auto_pulse = 2'b00;
  logic [1:0] txd;
  logic       auto_en = 1'b0;

  logic       fullA, emptyA, tvA, busyA, ovfA;
  logic       fullB, emptyB, tvB, busyB, ovfB;
  logic [2:0] cntA;
  logic [4:0] cntB;
  logic [7:0] datA, datB;

  logic [1:0] d_full, d_empty, d_valid, d_busy, d_ovf;
  logic [7:0] d_dat [2];
  int         d_cnt [2];

  always #5 clk = ~clk;
  assign txd = auto_pulse | man_done;

  uart_tx_queue #(.DEPTH(4), .GAP_CYCLES(0)) u_a (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(fullA), .empty(emptyA), .count(cntA), .tx_data(datA),
    .tx_valid(tvA), .tx_done(txd[0]), .busy(busyA), .overflow(ovfA));

  uart_tx_queue #(.DEPTH(16), .GAP_CYCLES(3)) u_b (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
    .full(fullB), .empty(emptyB), .count(cntB), .tx_data(datB),
    .tx_valid(tvB), .tx_done(txd[1]), .busy(busyB), .overflow(ovfB));

  always_comb begin
    d_full  = {fullB, fullA};
    d_empty = {emptyB, emptyA};
    d_valid = {tvB, tvA};
    d_busy  = {busyB, busyA};
    d_ovf   = {ovfB, ovfA};
    d_dat[0] = datA;
    d_dat[1] = datB;
    d_cnt[0] = int'(cntA);
    d_cnt[1] = int'(cntB);
  end

  // ---------------- transmitter stand-in: tx_done 20 cycles after tx_valid
  int rcnt [2] = '{0, 0};
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      auto_pulse[i] = 1'b0;
      if (rcnt[i] > 0) begin
        rcnt[i] = rcnt[i] - 1;
        if (rcnt[i] == 0) auto_pulse[i] = 1'b1;
      end
      if (auto_en && d_valid[i]) rcnt[i] = 20;
      if (reset) rcnt[i] = 0;
    end
  end

  // ---------------- behavioural model + per-cycle compare
  int         cyc = 0;
  int         m_tests = 0, m_errs = 0;
  logic [7:0] mbuf [2][32];
  int         mhead [2], msize [2];
  logic [7:0] mcur [2];
  bit         minfl [2], movf [2];
  int         missue [2], mgapend [2];
  int         vl_n [2] = '{0, 0};
  int         vl_cyc [2][64];
  logic [7:0] vl_dat [2][64];
  int         dl_n [2] = '{0, 0};
  int         dl_cyc [2][64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit         e_valid, e_busy, e_full, e_empty, e_ovf;
      logic [7:0] e_dat;
      bit         pop;
      int         pre;
      if (cyc > 0) begin
        e_valid = (cyc == missue[i]);
        e_dat   = mcur[i];
        e_busy  = minfl[i] || (cyc <= mgapend[i]);
        e_full  = (msize[i] == ND[i]);
        e_empty = (msize[i] == 0);
`ifdef UART_TXQ_OVERFLOW_EN
        e_ovf = movf[i];
`else
        e_ovf = 1'b0;
`endif
        m_tests++;
        if (d_valid[i] !== e_valid || d_dat[i] !== e_dat || d_busy[i] !== e_busy ||
            d_cnt[i] != msize[i] || d_full[i] !== e_full || d_empty[i] !== e_empty ||
            d_ovf[i] !== e_ovf) begin
          m_errs++;
          $display("FAIL model cyc%0d dut%0d got/exp: valid=%0b/%0b data=%02h/%02h busy=%0b/%0b count=%0d/%0d full=%0b/%0b empty=%0b/%0b ovf=%0b/%0b",
                   cyc, i, d_valid[i], e_valid, d_dat[i], e_dat, d_busy[i], e_busy,
                   d_cnt[i], msize[i], d_full[i], e_full, d_empty[i], e_empty, d_ovf[i], e_ovf);
        end
        if (d_valid[i] && vl_n[i] < 64) begin
          vl_cyc[i][vl_n[i]] = cyc;
          vl_dat[i][vl_n[i]] = d_dat[i];
          vl_n[i]++;
        end
        if (txd[i] && dl_n[i] < 64) begin
          dl_cyc[i][dl_n[i]] = cyc;
          dl_n[i]++;
        end
      end
      if (reset) begin
        mhead[i] = 0; msize[i] = 0; mcur[i] = 8'h00; minfl[i] = 0; movf[i] = 0;
        missue[i] = -10; mgapend[i] = -10;
      end else begin
        pre = msize[i];
        // next byte is handed over once the previous frame and its gap are done
        pop = !minfl[i] && (cyc > mgapend[i]) && (pre > 0);
        if (minfl[i] && cyc > missue[i] && txd[i]) begin
          minfl[i]   = 0;
          mgapend[i] = cyc + NG[i];
        end
        if (pop) begin
          mcur[i]   = mbuf[i][mhead[i]];
          mhead[i]  = (mhead[i] + 1) % 32;
          msize[i]  = msize[i] - 1;
          minfl[i]  = 1;
          missue[i] = cyc + 1;
        end
        if (wr_en) begin
          if (pre < ND[i]) begin
            mbuf[i][(mhead[i] + msize[i]) % 32] = wr_data;
            msize[i] = msize[i] + 1;
          end else begin
            movf[i] = 1;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- directed stimulus + literal checks
  int c_tests = 0, c_errs = 0;

  task automatic chk(input string nm, input int got, input int exp);
    c_tests++;
    if (got != exp) begin
      c_errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int w, b0, b1, db0, db1;
    tick();
    tick();
    // reset state
    chk("rst_count", d_cnt[0], 0);
    chk("rst_empty", int'(emptyA), 1);
    chk("rst_full", int'(fullA), 0);
    chk("rst_busy", int'(busyA), 0);
    chk("rst_valid", int'(tvA), 0);
    chk("rst_data", int'(datA), 0);
    chk("rst_ovf", int'(ovfA), 0);
    reset = 1'b0;

    // single byte
    auto_en = 1'b1;
    repeat (3) tick();
    b0 = vl_n[0]; b1 = vl_n[1];
    w = cyc;
    wr(8'hA5);
    repeat (40) tick();
    chk("single_pulses_A", vl_n[0] - b0, 1);
    chk("single_lat_A", vl_cyc[0][b0] - w, 2);
    chk("single_data_A", int'(vl_dat[0][b0]), 'hA5);
    chk("single_pulses_B", vl_n[1] - b1, 1);
    chk("single_lat_B", vl_cyc[1][b1] - w, 2);

    // burst 01..04
    b0 = vl_n[0]; b1 = vl_n[1]; db0 = dl_n[0]; db1 = dl_n[1];
    for (int k = 1; k <= 4; k++) wr(8'(k));
    repeat (200) tick();
    chk("burst_pulses_A", vl_n[0] - b0, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("burst_data_A%0d", k), int'(vl_dat[0][b0+k]), k + 1);
    for (int k = 1; k < 4; k++)
      chk($sformatf("burst_b2b_A%0d", k), vl_cyc[0][b0+k] - dl_cyc[0][db0+k-1], 2);
    chk("gap_b2b_B", vl_cyc[1][b1+1] - dl_cyc[1][db1], 5);
    chk("burst_data_B3", int'(vl_dat[1][b1+3]), 4);

    // stray tx_done in IDLE and ISSUE
    auto_en = 1'b0;
    b0 = vl_n[0];
    w = cyc;
    wr(8'h3C);
    man_done = 2'b11; tick();
    tick();
    man_done = 2'b00;
    repeat (4) tick();
    chk("stray_busy_A", int'(busyA), 1);
    chk("stray_busy_B", int'(busyB), 1);
    man_done = 2'b11; tick();
    man_done = 2'b00; tick();
    chk("stray_idle_A", int'(busyA), 0);
    chk("stray_gap_B", int'(busyB), 1);
    tick(); tick();
    chk("stray_idle_B", int'(busyB), 0);
    chk("stray_pulses_A", vl_n[0] - b0, 1);

    // full / overflow with stalled transmitter
    b0 = vl_n[0]; b1 = vl_n[1];
    for (int k = 0; k < 6; k++) wr(8'h10 + 8'(k));
    chk("full_count_A", d_cnt[0], 4);
    chk("full_flag_A", int'(fullA), 1);
    chk("full_count_B", d_cnt[1], 5);
`ifdef UART_TXQ_OVERFLOW_EN
    chk("ovf_A", int'(ovfA), 1);
`else
    chk("ovf_A", int'(ovfA), 0);
`endif
    chk("ovf_B", int'(ovfB), 0);
    man_done = 2'b11; tick();
    man_done = 2'b00;
    auto_en = 1'b1;
    repeat (250) tick();
    chk("full_pulses_A", vl_n[0] - b0, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("full_data_A%0d", k), int'(vl_dat[0][b0+k]), 'h10 + k);
    chk("full_pulses_B", vl_n[1] - b1, 6);
    chk("full_data_B5", int'(vl_dat[1][b1+5]), 'h15);

    // reset in WAIT with 3 bytes queued
    auto_en = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) wr(8'h20 + 8'(k));
    chk("prerst_count_A", d_cnt[0], 3);
    chk("prerst_busy_A", int'(busyA), 1);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("postrst_count_A", d_cnt[0], 0);
    chk("postrst_empty_A", int'(emptyA), 1);
    chk("postrst_busy_A", int'(busyA), 0);
    chk("postrst_busy_B", int'(busyB), 0);
    chk("postrst_ovf_A", int'(ovfA), 0);
    b0 = vl_n[0];
    repeat (10) tick();
    chk("postrst_quiet_A", vl_n[0] - b0, 0);
    wr(8'h5A);
    repeat (5) tick();
    chk("postrst_pulses_A", vl_n[0] - b0, 1);
    chk("postrst_data_A", int'(vl_dat[0][b0]), 'h5A);
    man_done = 2'b11; tick();
    man_done = 2'b00;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", m_tests + c_tests, m_errs + c_errs);
    $finish;
  end

endmodule
